// File: rtl/cmd_frame_parser_if.sv
// rtl/cmd_frame_parser_if.sv - RX byte stream and decoded command bus of the frame parser
interface cmd_frame_parser_if #(
    parameter int MAX_WORDS = 4
) ();
    logic [7:0]             rx_axis_tdata;
    logic                   rx_axis_tvalid;
    logic                   rx_axis_tlast;
    logic                   rx_axis_tready;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_chan;
    logic                   cmd_write;
    logic [31:0]            cmd_id;
    logic [31:0]            cmd_addr;
    logic [32*MAX_WORDS-1:0] cmd_data;
    logic [5:0]             cmd_nwords;
    logic [47:0]            cmd_src_mac;

    modport slave (
        input  rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, cmd_ready,
        output rx_axis_tready, cmd_valid, cmd_chan, cmd_write, cmd_id, cmd_addr,
               cmd_data, cmd_nwords, cmd_src_mac
    );

    modport master (
        output rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, cmd_ready,
        input  rx_axis_tready, cmd_valid, cmd_chan, cmd_write, cmd_id, cmd_addr,
               cmd_data, cmd_nwords, cmd_src_mac
    );
endinterface

// File: rtl/cmd_frame_parser.sv
// rtl/cmd_frame_parser.sv - Ethernet command-frame parser: MAC filter, tag/opcode decode, command handshake
module cmd_frame_parser #(
    parameter int          MAX_WORDS = 4,
    parameter logic [15:0] CHAN0_TAG = 16'h4343,
    parameter logic [15:0] CHAN1_TAG = 16'h4646,
    parameter logic [15:0] WR_TAG    = 16'h5757,
    parameter logic [15:0] RD_TAG    = 16'h5252
) (
    input  logic        gtx_clk_bufg,
    input  logic        gtx_resetn,
    input  logic [47:0] fpga_mac,
    input  logic        promisc,
    cmd_frame_parser_if.slave rx,
    output logic        frame_err,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_dropped
);

    typedef enum logic [2:0] {ST_SYNC, ST_HDR, ST_DATA, ST_DROP, ST_HOLD} state_t;

    state_t                  state;
    logic [7:0]              offset;
    logic [39:0]             dst_sr;
    logic [7:0]              tag_hi;
    logic [23:0]             word_sr;
    logic [1:0]              byte_idx;
    logic                    tready_r;
    logic                    cmd_valid_r;
    logic                    chan_r;
    logic                    write_r;
    logic [31:0]             id_r;
    logic [31:0]             addr_r;
    logic [32*MAX_WORDS-1:0] data_r;
    logic [5:0]              nwords_r;
    logic [47:0]             src_r;

    logic        beat;
    logic [7:0]  b;
    logic [47:0] dst_full;
    logic [15:0] tag_full;
    logic [31:0] word_full;
    logic [7:0]  offset_inc;
    logic        dst_ok;
    logic        filter_fail;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign beat       = rx.rx_axis_tvalid & tready_r;
    assign b          = rx.rx_axis_tdata;
    assign dst_full   = {dst_sr, b};
    assign tag_full   = {tag_hi, b};
    assign word_full  = {b, word_sr};
    assign offset_inc = (offset == 8'hFF) ? offset : offset + 8'd1;
    assign dst_ok     = promisc || (dst_full == fpga_mac) || (dst_full == 48'hFFFF_FFFF_FFFF);
    assign filter_fail = ((offset == 8'd5)  && !dst_ok) ||
                         ((offset == 8'd17) && (tag_full != CHAN0_TAG) && (tag_full != CHAN1_TAG)) ||
                         ((offset == 8'd19) && (tag_full != WR_TAG) && (tag_full != RD_TAG));

    always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
        if (!gtx_resetn) begin
            state          <= ST_SYNC;
            offset         <= '0;
            dst_sr         <= '0;
            tag_hi         <= '0;
            word_sr        <= '0;
            byte_idx       <= '0;
            tready_r       <= 1'b0;
            cmd_valid_r    <= 1'b0;
            chan_r         <= 1'b0;
            write_r        <= 1'b0;
            id_r           <= '0;
            addr_r         <= '0;
            data_r         <= '0;
            nwords_r       <= '0;
            src_r          <= '0;
            frame_err      <= 1'b0;
            frames_ok      <= '0;
            frames_dropped <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                // Whatever was in flight when reset hit is swallowed here.
                ST_SYNC: begin
                    tready_r <= 1'b1;
                    offset   <= '0;
                    if (!rx.rx_axis_tvalid || (beat && rx.rx_axis_tlast))
                        state <= ST_HDR;
                end
                ST_HDR: if (beat) begin
                    offset <= offset_inc;
                    if (offset == 8'd0) begin
                        data_r   <= '0;
                        nwords_r <= '0;
                        byte_idx <= '0;
                    end
                    if (offset < 8'd6)
                        dst_sr <= dst_full[39:0];
                    else if (offset < 8'd12)
                        src_r <= {src_r[39:0], b};
                    else if ((offset == 8'd16) || (offset == 8'd18))
                        tag_hi <= b;
                    else if (offset == 8'd17)
                        chan_r <= (tag_full == CHAN1_TAG);
                    else if (offset == 8'd19)
                        write_r <= (tag_full == WR_TAG);
                    else if ((offset >= 8'd20) && (offset < 8'd24))
                        id_r <= {b, id_r[31:8]};
                    else if (offset >= 8'd24)
                        addr_r <= {b, addr_r[31:8]};
                    // tlast wins over a filter failure on the same beat: one drop only.
                    if (rx.rx_axis_tlast) begin
                        offset <= '0;
                        if (offset == 8'd27) begin
                            state       <= ST_HOLD;
                            tready_r    <= 1'b0;
                            cmd_valid_r <= 1'b1;
                            frames_ok   <= sat_inc(frames_ok);
                        end else begin
                            frame_err      <= 1'b1;
                            frames_dropped <= sat_inc(frames_dropped);
                        end
                    end else if (filter_fail) begin
                        state <= ST_DROP;
                    end else if (offset == 8'd27) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: if (beat) begin
                    offset   <= offset_inc;
                    byte_idx <= byte_idx + 2'd1;
                    word_sr  <= word_full[31:8];
                    if ((byte_idx == 2'd3) && (nwords_r < 6'(MAX_WORDS))) begin
                        for (int k = 0; k < MAX_WORDS; k++)
                            if (nwords_r == 6'(k))
                                data_r[32*k +: 32] <= word_full;
                        nwords_r <= nwords_r + 6'd1;
                    end
                    if (rx.rx_axis_tlast) begin
                        offset      <= '0;
                        state       <= ST_HOLD;
                        tready_r    <= 1'b0;
                        cmd_valid_r <= 1'b1;
                        frames_ok   <= sat_inc(frames_ok);
                    end
                end
                ST_DROP: if (beat) begin
                    offset <= offset_inc;
                    if (rx.rx_axis_tlast) begin
                        offset         <= '0;
                        state          <= ST_HDR;
                        frame_err      <= 1'b1;
                        frames_dropped <= sat_inc(frames_dropped);
                    end
                end
                ST_HOLD: if (rx.cmd_ready) begin
                    cmd_valid_r <= 1'b0;
                    tready_r    <= 1'b1;
                    state       <= ST_HDR;
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

    assign rx.rx_axis_tready = tready_r;
    assign rx.cmd_valid      = cmd_valid_r;
    assign rx.cmd_chan       = chan_r;
    assign rx.cmd_write      = write_r;
    assign rx.cmd_id         = id_r;
    assign rx.cmd_addr       = addr_r;
    assign rx.cmd_data       = data_r;
    assign rx.cmd_nwords     = nwords_r;
    assign rx.cmd_src_mac    = src_r;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb/tb_cmd_frame_parser.sv - table-driven frame vectors plus hold, runt and mid-frame reset sequences
module tb_cmd_frame_parser;
    localparam int          MW     = 4;
    localparam logic [47:0] MY_MAC = 48'h5a0102030405;

    logic        clk = 1'b0;
    logic        rstn;
    logic        promisc;
    logic        frame_err;
    logic [15:0] frames_ok;
    logic [15:0] frames_dropped;

    cmd_frame_parser_if #(.MAX_WORDS(MW)) bus ();

    cmd_frame_parser #(.MAX_WORDS(MW)) dut (
        .gtx_clk_bufg   (clk),
        .gtx_resetn     (rstn),
        .fpga_mac       (MY_MAC),
        .promisc        (promisc),
        .rx             (bus),
        .frame_err      (frame_err),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_okc = 0;
    int exp_dropc = 0;

    typedef struct {
        logic [47:0]  dst;
        logic [47:0]  src;
        logic [15:0]  typ;
        logic [15:0]  op;
        logic [31:0]  id;
        logic [31:0]  addr;
        int           ndata;
        logic [255:0] dbytes;
        logic         prom;
        logic         ok;
        logic         chan;
        logic         wr;
        logic [5:0]   nw;
        logic [127:0] data;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] fq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic build(input vec_t v);
        fq.delete();
        for (int i = 0; i < 6; i++) fq.push_back(v.dst[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) fq.push_back(v.src[8*(5-i) +: 8]);
        fq.push_back(8'h00); fq.push_back(8'h2c); fq.push_back(8'h00); fq.push_back(8'h00);
        fq.push_back(v.typ[15:8]); fq.push_back(v.typ[7:0]);
        fq.push_back(v.op[15:8]);  fq.push_back(v.op[7:0]);
        for (int i = 0; i < 4; i++) fq.push_back(v.id[8*i +: 8]);
        for (int i = 0; i < 4; i++) fq.push_back(v.addr[8*i +: 8]);
        for (int i = 0; i < v.ndata; i++) fq.push_back(v.dbytes[8*i +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int guard = 0;
        bus.rx_axis_tdata  = d;
        bus.rx_axis_tvalid = 1'b1;
        bus.rx_axis_tlast  = l;
        while (!bus.rx_axis_tready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.rx_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_q(input int upto);
        for (int i = 0; i < upto; i++) send_byte(fq[i], (i == upto - 1));
        bus.rx_axis_tvalid = 1'b0;
        bus.rx_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.rx_axis_tvalid = 1'b0;
        bus.rx_axis_tlast  = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_cmd(input string tag, input vec_t v);
        chk({tag, "_chan"},   bus.cmd_chan,    v.chan);
        chk({tag, "_write"},  bus.cmd_write,   v.wr);
        chk({tag, "_id"},     bus.cmd_id,      v.id);
        chk({tag, "_addr"},   bus.cmd_addr,    v.addr);
        chk({tag, "_nwords"}, bus.cmd_nwords,  v.nw);
        chk({tag, "_data"},   bus.cmd_data,    v.data);
        chk({tag, "_src"},    bus.cmd_src_mac, v.src);
    endtask

    task automatic handshake(input string tag);
        bus.cmd_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_ready = 1'b0;
        chk({tag, "_valid_fall"},  bus.cmd_valid,      1'b0);
        chk({tag, "_tready_rise"}, bus.rx_axis_tready, 1'b1);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_frames_ok"},      frames_ok,      16'(exp_okc));
        chk({tag, "_frames_dropped"}, frames_dropped, 16'(exp_dropc));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        promisc = 1'b0;
        bus.rx_axis_tdata  = '0;
        bus.rx_axis_tvalid = 1'b0;
        bus.rx_axis_tlast  = 1'b0;
        bus.cmd_ready      = 1'b0;

        vecs[0] = '{dst:MY_MAC, src:48'h001122334455, typ:16'h4343, op:16'h5757,
                    id:32'h00004727, addr:32'h000000c8, ndata:8, dbytes:256'h00000001_00000300,
                    prom:1'b0, ok:1'b1, chan:1'b0, wr:1'b1, nw:6'd2, data:128'h00000001_00000300};
        vecs[1] = '{dst:MY_MAC, src:48'h0a0b0c0d0e0f, typ:16'h4646, op:16'h5252,
                    id:32'h12345678, addr:32'hdeadbeef, ndata:0, dbytes:256'h0,
                    prom:1'b0, ok:1'b1, chan:1'b1, wr:1'b0, nw:6'd0, data:128'h0};
        vecs[2] = '{dst:48'h985aebdb066f, src:48'h000000000001, typ:16'h4343, op:16'h5757,
                    id:32'h1, addr:32'h2, ndata:4, dbytes:256'h11223344,
                    prom:1'b0, ok:1'b0, chan:1'b0, wr:1'b0, nw:6'd0, data:128'h0};
        vecs[3] = '{dst:48'h985aebdb066f, src:48'h000000000002, typ:16'h4343, op:16'h5252,
                    id:32'hcafef00d, addr:32'h10, ndata:4, dbytes:256'h04030201,
                    prom:1'b1, ok:1'b1, chan:1'b0, wr:1'b0, nw:6'd1, data:128'h04030201};
        vecs[4] = '{dst:MY_MAC, src:48'h000000000003, typ:16'h4646, op:16'h5757,
                    id:32'h00000007, addr:32'h00000100, ndata:28,
                    dbytes:256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111,
                    prom:1'b0, ok:1'b1, chan:1'b1, wr:1'b1, nw:6'd4,
                    data:128'h44444444_33333333_22222222_11111111};
        vecs[5] = '{dst:48'hffffffffffff, src:48'h000000000004, typ:16'h4343, op:16'h5757,
                    id:32'h0000abcd, addr:32'h00000020, ndata:6, dbytes:256'hb2b1_a4a3a2a1,
                    prom:1'b0, ok:1'b1, chan:1'b0, wr:1'b1, nw:6'd1, data:128'ha4a3a2a1};
        vecs[6] = '{dst:MY_MAC, src:48'h000000000005, typ:16'h4444, op:16'h5757,
                    id:32'h1, addr:32'h1, ndata:4, dbytes:256'h1,
                    prom:1'b0, ok:1'b0, chan:1'b0, wr:1'b0, nw:6'd0, data:128'h0};
        vecs[7] = '{dst:MY_MAC, src:48'h000000000006, typ:16'h4646, op:16'h5758,
                    id:32'h1, addr:32'h1, ndata:4, dbytes:256'h1,
                    prom:1'b0, ok:1'b0, chan:1'b0, wr:1'b0, nw:6'd0, data:128'h0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tready",    bus.rx_axis_tready, 1'b0);
        chk("reset_valid",     bus.cmd_valid,      1'b0);
        chk("reset_frame_err", frame_err,          1'b0);
        chk("reset_nwords",    bus.cmd_nwords,     6'd0);
        chk_counters("reset");
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("tready_first_edge", bus.rx_axis_tready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            promisc = vecs[i].prom;
            build(vecs[i]);
            send_q(fq.size());
            chk({tag, "_valid"},     bus.cmd_valid, vecs[i].ok);
            chk({tag, "_frame_err"}, frame_err,     !vecs[i].ok);
            if (vecs[i].ok) begin
                exp_okc++;
                check_cmd(tag, vecs[i]);
                handshake(tag);
            end else begin
                exp_dropc++;
                idle(1);
                chk({tag, "_err_pulse_end"}, frame_err, 1'b0);
            end
            chk_counters(tag);
            idle(2);
        end
        promisc = 1'b0;

        build(vecs[0]);
        send_q(16);
        exp_dropc++;
        chk("runt15_frame_err", frame_err,     1'b1);
        chk("runt15_valid",     bus.cmd_valid, 1'b0);
        idle(1);
        chk_counters("runt15");

        build(vecs[2]);
        send_q(6);
        exp_dropc++;
        chk("runt_dst_frame_err", frame_err, 1'b1);
        idle(2);
        chk_counters("runt_dst");

        build(vecs[0]);
        send_q(fq.size());
        exp_okc++;
        chk("hold_valid_rise", bus.cmd_valid, 1'b1);
        build(vecs[1]);
        bus.rx_axis_tdata  = fq[0];
        bus.rx_axis_tvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_c%0d", c),
                {bus.rx_axis_tready, bus.cmd_valid, bus.cmd_nwords, bus.cmd_id, bus.cmd_data[63:0]},
                {1'b0, 1'b1, 6'd2, 32'h00004727, 64'h00000001_00000300});
        end
        handshake("hold");
        send_q(fq.size());
        exp_okc++;
        chk("b2b_valid", bus.cmd_valid, 1'b1);
        check_cmd("b2b", vecs[1]);
        handshake("b2b");
        chk_counters("b2b");
        idle(2);

        build(vecs[0]);
        for (int i = 0; i < 10; i++) send_byte(fq[i], 1'b0);
        bus.rx_axis_tdata = fq[10];
        rstn = 1'b0;
        #1;
        chk("midreset_outputs", {bus.rx_axis_tready, bus.cmd_valid, frames_ok, frames_dropped}, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_okc = 0;
        exp_dropc = 0;
        for (int i = 10; i < fq.size(); i++) send_byte(fq[i], (i == fq.size() - 1));
        bus.rx_axis_tvalid = 1'b0;
        bus.rx_axis_tlast  = 1'b0;
        chk("residue_frame_err", frame_err,     1'b0);
        chk("residue_valid",     bus.cmd_valid, 1'b0);
        idle(2);
        chk_counters("residue");
        build(vecs[1]);
        send_q(fq.size());
        exp_okc++;
        chk("post_reset_valid", bus.cmd_valid, 1'b1);
        check_cmd("post_reset", vecs[1]);
        handshake("post_reset");
        chk_counters("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

Parametrised Ethernet command-frame parser between the MAC RX AXI-Stream (8-bit) and the command/register logic inside `cmd_decoder_top`. It filters frames on destination MAC and decodes the channel tag (`CC`/`FF`) and the opcode (`WW`/`RR`). It extracts command ID, address and up to `MAX_WORDS` 32-bit data words, and presents each good frame as one command on a valid/ready interface. It back-pressures RX while a command waits and keeps saturating good/dropped frame counters.

## Interface
- `MAX_WORDS`, 4: maximum captured data words per frame; legal range 1–56.
- `CHAN0_TAG`, 16'h4343: type field for channel 0 (control).
- `CHAN1_TAG`, 16'h4646: type field for channel 1 (FMC).
- `WR_TAG`, 16'h5757: opcode field for write.
- `RD_TAG`, 16'h5252: opcode field for read.
- `gtx_clk_bufg` in 1: the single clock.
- `gtx_resetn` in 1: reset, asynchronous and active-low.
- `fpga_mac` in 48: station address, static.
- `promisc` in 1: when high, the destination MAC filter is disabled.
- `rx_axis_tdata` in 8, `rx_axis_tvalid` in 1, `rx_axis_tlast` in 1: frame byte stream.
- `rx_axis_tready` out 1: stream back-pressure.
- `cmd_valid` out 1 / `cmd_ready` in 1: command handshake.
- `cmd_chan` out 1: 0 = `CHAN0_TAG`, 1 = `CHAN1_TAG`.
- `cmd_write` out 1: 1 = `WR_TAG`, 0 = `RD_TAG`.
- `cmd_id` out 32, `cmd_addr` out 32: little-endian fields of the frame.
- `cmd_data` out 32*MAX_WORDS: word k occupies bits [32k+31:32k]; unused words are 0.
- `cmd_nwords` out 6: number of captured words, 0..`MAX_WORDS`.
- `cmd_src_mac` out 48: source MAC of the frame.
- `frame_err` out 1: single-cycle pulse when a frame is dropped.
- `frames_ok` out 16, `frames_dropped` out 16: saturating counters.

## Operation
- **Byte offsets**, counted per accepted beat (`tvalid & tready`):
  - 0–5: destination MAC.
  - 6–11: source MAC.
  - 12–15: length and reserved, ignored.
  - 16–17: type, first byte is the MSB.
  - 18–19: opcode, first byte is the MSB.
  - 20–23: ID, first byte is the LSB.
  - 24–27: address, first byte is the LSB.
  - 28 onward: data words, each LSB first.
- **Offset counter**: 8 bits, saturates at 255 and is cleared on tlast.
- **States**:
  - SYNC: entered from reset. Discards beats. Goes to IDLE on the first cycle with `tvalid`=0, or after an accepted tlast beat.
  - HDR: offsets 0–27. After offset 5, if the destination does not match `fpga_mac`, is not 48'hFFFFFFFFFFFF, and `promisc`=0, go to DROP. After offset 17, an unknown type goes to DROP. After offset 19, an unknown opcode goes to DROP.
  - DATA: offset ≥ 28. Captures complete words while `nwords` < `MAX_WORDS`. Extra words and a trailing partial word are discarded.
  - DROP: discards beats until tlast, then pulses `frame_err`, increments `frames_dropped`, and returns to IDLE.
  - HOLD: `cmd_valid`=1 and `tready`=0. Goes to IDLE on `cmd_valid & cmd_ready`.
- IDLE and HDR are the same state, with offset 0 meaning IDLE.
- **tlast in HDR**:
  - At offset 27: good frame with `nwords`=0.
  - Before offset 27 (runt): treated as DROP completion.
- **tlast in DATA**: good frame; go to HOLD and increment `frames_ok`.
- **Counters**: saturate at 16'hFFFF and never wrap.
- **Data register**: cleared at the start of each frame, so stale words never leak.

## Timing
- **Reset values**: every output is 0, including `rx_axis_tready`. After release, `tready`=1 from the first rising edge. The block starts in SYNC.
- **tready**: 1 in SYNC, HDR, DATA and DROP; 0 only in HOLD.
- **cmd_valid**:
  - Rises on the edge that accepts the tlast beat of a good frame (latency 1 cycle after tlast beat).
  - Held with all `cmd_*` fields stable until `cmd_ready` is sampled high.
  - Falls, and `tready` rises, on that same edge.
- **Throughput**: back-to-back frames lose at most 1 cycle.
- **frame_err**: pulses on the cycle after the tlast beat of a dropped frame.
- **Gaps**: `tvalid` gaps inside a frame are tolerated in every state except SYNC.
- **Asynchronous reset mid-frame**: aborts the frame with no command and no counter change. The residue of the frame is discarded in SYNC.
- **Simultaneous events**: a tlast beat and a filter failure on the same beat (runt) counts exactly one drop.

## Test plan
- Write frame with dst 5a0102030405, type 4343, op 5757, ID bytes 27 47 00 00, address c8 00 00 00, data 00 03 00 00 01 00 00 00 and tlast -> `cmd_chan`=0, `cmd_write`=1, `cmd_id`=32'h00004727, `cmd_addr`=32'h000000c8, word0=32'h00000300, word1=32'h00000001, `cmd_nwords`=2, `frames_ok`=1.
- Read frame with type 4646, op 5252 and tlast at offset 27 -> `cmd_chan`=1, `cmd_write`=0, `cmd_nwords`=0, `cmd_data`=0.
- Destination 985aebdb066f with `promisc`=0 -> `frame_err` pulse, `frames_dropped`=1, no `cmd_valid`. Repeat with `promisc`=1 -> command issued.
- Frame with 7 data words and `MAX_WORDS`=4 -> `cmd_nwords`=4, words 0–3 match. Runt with tlast at offset 15 -> one drop.
- `cmd_ready` held 0 for 50 cycles -> `tready`=0 and fields stable for 50 cycles. The next frame is accepted 1 cycle after the handshake.
- Assert `gtx_resetn` at offset 10, release, then continue the frame and send a good frame -> residue is dropped silently, the good frame decodes, and the counters read 1/0.
